multi_vend_ctrl: RTL and testbench
==================================

MULTI_VEND_CTRL -- requirements
Module: multi_vend_ctrl

Interface
REQ-001 Parameter NUM_PROD, 4, number of selectable products, range 2..16.
REQ-002 Parameter CREDIT_W, 8, width of credit and price values in coin units.
REQ-003 Parameter MAX_CREDIT, 200, credit ceiling, at most 2**CREDIT_W-1.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 coin_valid  input  1  one-cycle coin insertion strobe.
REQ-007 coin_code  input  2  coin denomination: 0=1, 1=2, 2=5, 3=10 units.
REQ-008 sel_valid  input  1  one-cycle product selection strobe.
REQ-009 sel_id  input  4  selected product index.
REQ-010 price_tbl  input  NUM_PROD*CREDIT_W  packed per-product prices; product i at bits [i*CREDIT_W +: CREDIT_W].
REQ-011 vend_ack  input  1  dispenser acknowledges the vend.
REQ-012 cancel  input  1  refund request; present only when VEND_CANCEL_EN is defined.
REQ-013 credit  output  CREDIT_W  current credit, registered.
REQ-014 vend_valid  output  1  vend request, held until acknowledged.
REQ-015 vend_id  output  4  product being vended, stable while vend_valid is high.
REQ-016 change_pulse  output  1  one unit of change returned per high cycle.
REQ-017 coin_reject  output  1  one-cycle pulse: coin not accepted.
REQ-018 sel_reject  output  1  one-cycle pulse: selection not accepted.
REQ-019 busy  output  1  high in VEND and CHANGE states.

Function
REQ-020 States: IDLE (credit=0), CREDIT (credit>0), VEND, CHANGE.
REQ-021 Coin handling in IDLE/CREDIT:
- If credit plus the coin value is at most MAX_CREDIT, the coin is accepted and credit updates on the next edge; IDLE moves to CREDIT.
- Otherwise coin_reject pulses on the next cycle and credit is unchanged.
REQ-022 Selection in IDLE/CREDIT with sel_id < NUM_PROD and credit >= price: next cycle state=VEND, vend_valid=1, vend_id=sel_id.
REQ-023 Selection rejected (sel_reject pulse next cycle, no state change) when:
- sel_id >= NUM_PROD;
- credit < price;
- coin_valid is high in the same cycle (the coin takes priority and is processed per REQ-021).
REQ-024 VEND: vend_valid held until the cycle vend_ack=1. On that edge, credit becomes credit minus price (price latched at selection), and the state goes to CHANGE if the remainder is >0, else IDLE.
REQ-025 CHANGE: change_pulse=1 each cycle; credit decrements by 1 per pulse; on the edge where credit reaches 0, the state goes to IDLE and change_pulse deasserts the following cycle.
REQ-026 In VEND/CHANGE, every coin_valid produces coin_reject and every sel_valid produces sel_reject; credit is unaffected except by REQ-024/REQ-025.
REQ-027 vend_ack outside VEND is ignored.
REQ-028 Latched price is used for VEND; price_tbl changes after selection have no effect.

Reset
REQ-029 While rstn=0 at an edge: state=IDLE, credit=0, and vend_valid, vend_id, change_pulse, coin_reject, sel_reject, busy all 0.
REQ-030 Reset in any state, including mid-VEND or mid-CHANGE, discards credit and all pending vend/change with no further pulses.

Configuration
REQ-031 Macro VEND_CANCEL_EN.
- Defined: cancel=1 in CREDIT moves the state to CHANGE and refunds the entire credit per REQ-025. cancel in IDLE/VEND/CHANGE is ignored. cancel has priority over coin_valid and sel_valid in the same cycle; both strobes are then rejected.
- Undefined: no cancel port; credit is returned only as change after a vend.

Structure
REQ-032 Package vend_pkg holds:
- state enum type;
- coin code typedef;
- coin value constants (1, 2, 5, 10).
REQ-033 Sub-module vend_coin_decode maps coin_code to a CREDIT_W-bit value; all other logic lives in multi_vend_ctrl.

Verification (NUM_PROD=4, CREDIT_W=8, MAX_CREDIT=20, prices 7,12,15,20)
REQ-034 Coins 10 then 5, select id 2 -> credit=15, then vend_valid=1 with vend_id=2; on ack credit=0, state IDLE, zero change_pulse cycles.
REQ-035 Coins 10 and 10, select id 0, ack -> exactly 13 consecutive change_pulse cycles, credit counts 13 down to 0, then IDLE.
REQ-036 Credit 5, select id 3 -> one sel_reject pulse, credit stays 5; select id 5 -> sel_reject.
REQ-037 Credit 15, insert 10 -> coin_reject pulse, credit stays 15; a coin+select in the same cycle -> coin accepted, sel_reject pulse.
REQ-038 rstn low during the 4th change_pulse -> next cycle all outputs 0, credit 0, no further pulses.
REQ-039 With VEND_CANCEL_EN, credit 12, cancel -> 12 change_pulse cycles, then IDLE; with vend_valid high, cancel -> no effect.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the multi-product vending controller.
// Optional refund feature: VEND_CANCEL_EN.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } vend_state_e;

    typedef logic [1:0] coin_code_t;

    localparam int COIN_VAL_1  = 1;
    localparam int COIN_VAL_2  = 2;
    localparam int COIN_VAL_5  = 5;
    localparam int COIN_VAL_10 = 10;

endpackage

// File: rtl/vend_coin_decode.sv
// Coin denomination decoder: coin code to credit units.
// Used by multi_vend_ctrl (VEND_CANCEL_EN has no effect here).
module vend_coin_decode
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  coin_code_t          code_i,
    output logic [CREDIT_W-1:0] value_o
);

    always_comb begin
        value_o = '0;
        unique case (code_i)
            2'd0: value_o = CREDIT_W'(COIN_VAL_1);
            2'd1: value_o = CREDIT_W'(COIN_VAL_2);
            2'd2: value_o = CREDIT_W'(COIN_VAL_5);
            2'd3: value_o = CREDIT_W'(COIN_VAL_10);
            default: value_o = '0;
        endcase
    end

endmodule

// File: rtl/multi_vend_ctrl.sv
// Multi-product vending controller: credit, selection, vend handshake, change.
// Define VEND_CANCEL_EN to add the cancel (full refund) input.
module multi_vend_ctrl
    import vend_pkg::*;
#(
    parameter int NUM_PROD   = 4,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 200
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         coin_valid,
    input  logic [1:0]                   coin_code,
    input  logic                         sel_valid,
    input  logic [3:0]                   sel_id,
    input  logic [NUM_PROD*CREDIT_W-1:0] price_tbl,
    input  logic                         vend_ack,
`ifdef VEND_CANCEL_EN
    input  logic                         cancel,
`endif
    output logic [CREDIT_W-1:0]          credit,
    output logic                         vend_valid,
    output logic [3:0]                   vend_id,
    output logic                         change_pulse,
    output logic                         coin_reject,
    output logic                         sel_reject,
    output logic                         busy
);

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] price_q, price_d;
    logic [3:0]          vend_id_q, vend_id_d;
    logic                coin_rej_q, coin_rej_d;
    logic                sel_rej_q, sel_rej_d;

    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W-1:0] remain;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    logic                sel_ok;
    logic                do_cancel;

    vend_coin_decode #(
        .CREDIT_W (CREDIT_W)
    ) u_coin_decode (
        .code_i  (coin_code),
        .value_o (coin_val)
    );

    // One extra bit so the ceiling check cannot wrap.
    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_ok  = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
    assign remain   = credit_q - price_q;

    always_comb begin
        sel_price = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (sel_id == 4'(i)) begin
                sel_price = price_tbl[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    assign sel_ok = (int'(sel_id) < NUM_PROD) && (credit_q >= sel_price);

`ifdef VEND_CANCEL_EN
    assign do_cancel = cancel && (state_q == ST_CREDIT);
`else
    assign do_cancel = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        price_d    = price_q;
        vend_id_d  = vend_id_q;
        coin_rej_d = 1'b0;
        sel_rej_d  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (do_cancel) begin
                    coin_rej_d = coin_valid;
                    sel_rej_d  = sel_valid;
                    state_d    = ST_CHANGE;
                end else if (coin_valid) begin
                    // A coin in the same cycle always wins over a selection.
                    sel_rej_d = sel_valid;
                    if (coin_ok) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = ST_CREDIT;
                    end else begin
                        coin_rej_d = 1'b1;
                    end
                end else if (sel_valid) begin
                    if (sel_ok) begin
                        state_d   = ST_VEND;
                        price_d   = sel_price;
                        vend_id_d = sel_id;
                    end else begin
                        sel_rej_d = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                coin_rej_d = coin_valid;
                sel_rej_d  = sel_valid;
                if (vend_ack) begin
                    credit_d  = remain;
                    vend_id_d = '0;
                    state_d   = (remain != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                coin_rej_d = coin_valid;
                sel_rej_d  = sel_valid;
                if (credit_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    credit_d = credit_q - 1'b1;
                    if (credit_q == CREDIT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            credit_q   <= '0;
            price_q    <= '0;
            vend_id_q  <= '0;
            coin_rej_q <= 1'b0;
            sel_rej_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            price_q    <= price_d;
            vend_id_q  <= vend_id_d;
            coin_rej_q <= coin_rej_d;
            sel_rej_q  <= sel_rej_d;
        end
    end

    assign credit       = credit_q;
    assign vend_valid   = (state_q == ST_VEND);
    assign vend_id      = vend_id_q;
    assign change_pulse = (state_q == ST_CHANGE);
    assign coin_reject  = coin_rej_q;
    assign sel_reject   = sel_rej_q;
    assign busy         = (state_q == ST_VEND) || (state_q == ST_CHANGE);

endmodule

// File: tb/tb_multi_vend_ctrl.sv
// Directed bench for multi_vend_ctrl (MAX_CREDIT=20, prices 7,12,15,20).
// Cancel steps are built only with VEND_CANCEL_EN.
module tb_multi_vend_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        coin_valid;
    logic [1:0]  coin_code;
    logic        sel_valid;
    logic [3:0]  sel_id;
    logic [31:0] price_tbl;
    logic        vend_ack;
`ifdef VEND_CANCEL_EN
    logic        cancel;
`endif
    logic [7:0]  credit;
    logic        vend_valid;
    logic [3:0]  vend_id;
    logic        change_pulse;
    logic        coin_reject;
    logic        sel_reject;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multi_vend_ctrl #(
        .NUM_PROD   (4),
        .CREDIT_W   (8),
        .MAX_CREDIT (20)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .coin_valid   (coin_valid),
        .coin_code    (coin_code),
        .sel_valid    (sel_valid),
        .sel_id       (sel_id),
        .price_tbl    (price_tbl),
        .vend_ack     (vend_ack),
`ifdef VEND_CANCEL_EN
        .cancel       (cancel),
`endif
        .credit       (credit),
        .vend_valid   (vend_valid),
        .vend_id      (vend_id),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .sel_reject   (sel_reject),
        .busy         (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] c);
        coin_valid = 1'b1;
        coin_code  = c;
        step();
        coin_valid = 1'b0;
    endtask

    task automatic sel(input logic [3:0] id);
        sel_valid = 1'b1;
        sel_id    = id;
        step();
        sel_valid = 1'b0;
    endtask

    task automatic ack();
        vend_ack = 1'b1;
        step();
        vend_ack = 1'b0;
    endtask

    initial begin
        int k;
        rstn       = 1'b0;
        coin_valid = 1'b0;
        coin_code  = 2'd0;
        sel_valid  = 1'b0;
        sel_id     = 4'd0;
        vend_ack   = 1'b0;
`ifdef VEND_CANCEL_EN
        cancel     = 1'b0;
`endif
        price_tbl  = {8'd20, 8'd15, 8'd12, 8'd7};
        step();
        step();
        chk("rst_credit", credit, 0);
        chk("rst_vv", vend_valid, 0);
        chk("rst_vid", vend_id, 0);
        chk("rst_chg", change_pulse, 0);
        chk("rst_crej", coin_reject, 0);
        chk("rst_srej", sel_reject, 0);
        chk("rst_busy", busy, 0);
        rstn = 1'b1;
        step();

        // Exact-price vend, no change
        coin(2'd3);
        chk("t1_c10", credit, 10);
        coin(2'd2);
        chk("t1_c15", credit, 15);
        sel(4'd2);
        chk("t1_vv", vend_valid, 1);
        chk("t1_vid", vend_id, 2);
        chk("t1_busy", busy, 1);
        chk("t1_cred", credit, 15);
        coin_valid = 1'b1;
        coin_code  = 2'd0;
        sel_valid  = 1'b1;
        sel_id     = 4'd0;
        step();
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        chk("t1_vcrej", coin_reject, 1);
        chk("t1_vsrej", sel_reject, 1);
        chk("t1_vhold", vend_valid, 1);
        chk("t1_vcred", credit, 15);
        step();
        chk("t1_hold2", vend_valid, 1);
        chk("t1_vid2", vend_id, 2);
        ack();
        chk("t1_acred", credit, 0);
        chk("t1_avv", vend_valid, 0);
        chk("t1_achg", change_pulse, 0);
        chk("t1_abusy", busy, 0);
        k = 0;
        for (int i = 0; i < 3; i++) begin
            if (change_pulse) k++;
            step();
        end
        chk("t1_nochg", k, 0);
        ack();
        chk("t1_strayack", credit, 0);

        // Vend with 13 units of change
        coin(2'd3);
        coin(2'd3);
        chk("t2_c20", credit, 20);
        sel(4'd0);
        chk("t2_vv", vend_valid, 1);
        ack();
        k = 0;
        while (change_pulse && k < 40) begin
            chk("t2_cnt", credit, 13 - k);
            k++;
            step();
        end
        chk("t2_pulses", k, 13);
        chk("t2_cred0", credit, 0);
        chk("t2_busy", busy, 0);

        // Rejected selections
        coin(2'd2);
        chk("t3_c5", credit, 5);
        sel(4'd3);
        chk("t3_srej", sel_reject, 1);
        chk("t3_cred", credit, 5);
        chk("t3_vv", vend_valid, 0);
        step();
        chk("t3_srej_1cyc", sel_reject, 0);
        sel(4'd5);
        chk("t3_srej_id", sel_reject, 1);
        chk("t3_vv2", vend_valid, 0);

        // Coin over ceiling, coin+select collision
        coin(2'd3);
        chk("t4_c15", credit, 15);
        coin(2'd3);
        chk("t4_crej", coin_reject, 1);
        chk("t4_cred", credit, 15);
        step();
        chk("t4_crej_1cyc", coin_reject, 0);
        coin_valid = 1'b1;
        coin_code  = 2'd0;
        sel_valid  = 1'b1;
        sel_id     = 4'd0;
        step();
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        chk("t4_both_cred", credit, 16);
        chk("t4_both_srej", sel_reject, 1);
        chk("t4_both_crej", coin_reject, 0);
        chk("t4_both_vv", vend_valid, 0);
        coin(2'd1);
        coin(2'd1);
        chk("t4_c20", credit, 20);

        // Latched price, then reset during the 4th change pulse
        sel(4'd0);
        chk("t5_vv", vend_valid, 1);
        price_tbl = {8'd20, 8'd15, 8'd12, 8'd1};
        step();
        ack();
        price_tbl = {8'd20, 8'd15, 8'd12, 8'd7};
        chk("t5_latched", credit, 13);
        chk("t5_chg1", change_pulse, 1);
        step();
        step();
        step();
        chk("t5_chg4", change_pulse, 1);
        chk("t5_cred4", credit, 10);
        rstn = 1'b0;
        step();
        chk("t5_rcred", credit, 0);
        chk("t5_rchg", change_pulse, 0);
        chk("t5_rvv", vend_valid, 0);
        chk("t5_rbusy", busy, 0);
        rstn = 1'b1;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (change_pulse) k++;
        end
        chk("t5_nopulse", k, 0);
        chk("t5_cred_end", credit, 0);

`ifdef VEND_CANCEL_EN
        coin(2'd3);
        coin(2'd1);
        chk("t6_c12", credit, 12);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        k = 0;
        while (change_pulse && k < 40) begin
            chk("t6_cnt", credit, 12 - k);
            k++;
            step();
        end
        chk("t6_pulses", k, 12);
        chk("t6_cred0", credit, 0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("t6_idle_cancel", change_pulse, 0);
        coin(2'd3);
        sel(4'd0);
        chk("t6_vv", vend_valid, 1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("t6_vcancel_vv", vend_valid, 1);
        chk("t6_vcancel_cr", credit, 10);
        ack();
        k = 0;
        while (change_pulse && k < 40) begin
            k++;
            step();
        end
        chk("t6_vpulses", k, 3);
        chk("t6_vcred0", credit, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
